// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave capture slice: FSM encoding, default widths,
// and the signed-to-offset-binary conversion used for the display RAM.
package wave_pkg;

    localparam int SAMPLE_WIDTH_DEF = 18;
    localparam int DEPTH_LOG2_DEF   = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Flipping the sign bit maps two's complement onto 0..255 with zero at mid-scale.
    function automatic logic [7:0] to_offset_binary(input logic [7:0] top_bits);
        return {~top_bits[7], top_bits[6:0]};
    endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample-in / display-RAM-write bundle between music_player, wave_capture and the display.
// master = wave_capture side, slave = the producer/RAM/display side.
interface wave_capture_if
    import wave_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF
) ();

    logic                    new_sample_ready;
    logic [SAMPLE_WIDTH-1:0] new_sample_in;
    logic                    wave_display_idle;
    logic [DEPTH_LOG2:0]     write_address;
    logic                    write_enable;
    logic [7:0]              write_sample;
    logic                    read_index;

    modport master (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );

    modport slave (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );

endinterface

// File: rtl/zero_cross_detect.sv
// Purpose: flags a negative-to-non-negative sign change between successive accepted samples.
// Latency: trigger is combinational on the current strobe; prev_msb updates on every strobe.
// Backpressure: none, samples are never stalled.
module zero_cross_detect (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic sample_msb,
    output logic trigger
);

    logic prev_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_msb <= 1'b0;
        end else if (new_sample_ready) begin
            prev_msb <= sample_msb;
        end
    end

    assign trigger = new_sample_ready & prev_msb & ~sample_msb;

endmodule

// File: rtl/wave_capture.sv
// Purpose: triggered capture of 2^DEPTH_LOG2 samples into the non-displayed half of a double buffer;
//          optional decimation with `WAVE_CAPTURE_DECIMATE_EN. Latency: write 1 cycle after the strobe.
// Backpressure: none; samples arriving while a full buffer waits for display idle are dropped.
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int DECIM_LOG2   = 1
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master bus
);

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] count_q, count_d;
    logic                  trigger;
    logic                  keep_sample;
    logic                  do_write;
    logic                  do_swap;
    logic                  read_index_q;
    logic                  write_enable_q;
    logic [DEPTH_LOG2:0]   write_address_q;
    logic [7:0]            write_sample_q;
    logic                  unused_ok;

    zero_cross_detect u_zero_cross (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (bus.new_sample_ready),
        .sample_msb       (bus.new_sample_in[SAMPLE_WIDTH-1]),
        .trigger          (trigger)
    );

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic [DECIM_LOG2-1:0] phase_q, phase_next;

    assign phase_next  = phase_q + DECIM_LOG2'(1);
    assign keep_sample = (phase_next == '0);

    // Phase counts samples since the trigger, so the trigger itself is offset 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else if (state_q == ARMED && trigger) begin
            phase_q <= '0;
        end else if (state_q == ACTIVE && bus.new_sample_ready) begin
            phase_q <= phase_next;
        end
    end
`else
    assign keep_sample = 1'b1;
`endif

    // Low sample bits and DECIM_LOG2 (in the plain build) have no function here.
    assign unused_ok = ^bus.new_sample_in ^ (DECIM_LOG2 != 0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        do_write = 1'b0;
        do_swap  = 1'b0;
        case (state_q)
            ARMED: begin
                if (trigger) begin
                    do_write = 1'b1;
                    count_d  = count_q + DEPTH_LOG2'(1);
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.new_sample_ready && keep_sample) begin
                    do_write = 1'b1;
                    count_d  = count_q + DEPTH_LOG2'(1);
                    if (count_q == '1) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.wave_display_idle) begin
                    do_swap = 1'b1;
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // count_q is zero whenever ARMED, so it doubles as the write index for the trigger sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
            read_index_q    <= 1'b0;
        end else begin
            write_enable_q <= do_write;
            if (do_write) begin
                write_address_q <= {~read_index_q, count_q};
                write_sample_q  <= to_offset_binary(bus.new_sample_in[SAMPLE_WIDTH-1 -: 8]);
            end
            if (do_swap) begin
                read_index_q <= ~read_index_q;
            end
        end
    end

    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = write_address_q;
    assign bus.write_sample  = write_sample_q;
    assign bus.read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Scenario bench for wave_capture: random samples against a write-list reference model.
module tb_wave_capture;
    import wave_pkg::*;

    localparam int SW   = 18;
    localparam int DL   = 8;
    localparam int DC   = 1;
    localparam int NBUF = 1 << DL;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam int RATIO = 1 << DC;
`else
    localparam int RATIO = 1;
`endif

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t mon_w;

    int m_prev, m_capt, m_full, m_n, m_phase, m_rd;

    wave_capture_if #(.SAMPLE_WIDTH(SW), .DEPTH_LOG2(DL)) bus ();

    wave_capture #(.SAMPLE_WIDTH(SW), .DEPTH_LOG2(DL), .DECIM_LOG2(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.write_enable === 1'b1) begin
            mon_w.addr = int'(bus.write_address);
            mon_w.data = int'(bus.write_sample);
            mon_w.cyc  = cyc;
            obs_q.push_back(mon_w);
        end
    end

    // Reference: a capture is the list of writes a full stream of samples should produce.
    task automatic model_reset();
        m_prev = 0; m_capt = 0; m_full = 0; m_n = 0; m_phase = 0; m_rd = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic model_cycle(input bit rdy, input logic [SW-1:0] s, input bit idle);
        int  msb;
        int  v;
        bit  keep;
        wr_t w;
        msb  = int'(s[SW-1]);
        keep = 1'b0;
        if (m_full != 0) begin
            if (idle) begin
                m_rd   = 1 - m_rd;
                m_full = 0;
            end
        end else if (rdy) begin
            if (m_capt == 0) begin
                if (m_prev == 1 && msb == 0) begin
                    m_capt  = 1;
                    m_n     = 0;
                    m_phase = 0;
                    keep    = 1'b1;
                end
            end else begin
                m_phase = (m_phase + 1) % RATIO;
                keep    = (m_phase == 0);
            end
            if (keep) begin
                v      = $signed(s);
                w.addr = ((1 - m_rd) << DL) + m_n;
                w.data = ((v >>> (SW - 8)) + 128) & 255;
                w.cyc  = cyc + 1;
                exp_q.push_back(w);
                m_n = m_n + 1;
                if (m_n == NBUF) begin
                    m_capt = 0;
                    m_full = 1;
                end
            end
        end
        if (rdy) m_prev = msb;
    endtask

    task automatic drive(input bit rdy, input logic [SW-1:0] s, input bit idle);
        bus.new_sample_ready  = rdy;
        bus.new_sample_in     = s;
        bus.wave_display_idle = idle;
        if (!reset) model_cycle(rdy, s, idle);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_pos();
        return SW'($urandom_range(1, (1 << (SW - 1)) - 1));
    endfunction

    function automatic logic [SW-1:0] rand_neg();
        logic [SW-1:0] p;
        p = rand_pos();
        return -p;
    endfunction

    task automatic feed(input logic [SW-1:0] s, input int gap, input bit idle);
        drive(1'b1, s, idle);
        for (int g = 1; g < gap; g++) drive(1'b0, SW'($urandom), idle);
    endtask

    // Negative then positive sample to trigger, then n-1 arbitrary samples.
    task automatic capture_burst(input int n, input int gap);
        feed(rand_neg(), gap, 1'b0);
        feed(rand_pos(), gap, 1'b0);
        for (int k = 1; k < n; k++) feed(SW'($urandom), gap, 1'b0);
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(3);
        total++; if (bus.write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h want=0", bus.write_enable); end
        total++; if (bus.write_address !== '0) begin bad++; $display("FAIL reset_addr got=%0h want=0", bus.write_address); end
        total++; if (bus.write_sample !== '0) begin bad++; $display("FAIL reset_sample got=%0h want=0", bus.write_sample); end
        total++; if (bus.read_index !== 1'b0) begin bad++; $display("FAIL reset_rd got=%0h want=0", bus.read_index); end
        total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, ARMED); end
        total++; if (dut.count_q !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.count_q); end
    endtask

    task automatic test_capture();
        feed(-SW'(5), 4, 1'b0);
        feed(SW'(3), 4, 1'b0);
        for (int k = 0; k < 255; k++) feed(rand_pos(), 4, 1'b0);
        total++; if (obs_q.size() != NBUF) begin bad++; $display("FAIL cap_count got=%0d want=%0d", obs_q.size(), NBUF); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL cap_model_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (obs_q[k] != exp_q[k]) begin
                bad++;
                $display("FAIL cap_write[%0d] got=%0h/%0h@%0d want=%0h/%0h@%0d", k, obs_q[k].addr, obs_q[k].data,
                         obs_q[k].cyc, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
        if (obs_q.size() == NBUF) begin
            total++; if (obs_q[0].addr != 'h100) begin bad++; $display("FAIL cap_first_addr got=%0h want=100", obs_q[0].addr); end
            total++; if (obs_q[NBUF-1].addr != 'h1FF) begin bad++; $display("FAIL cap_last_addr got=%0h want=1ff", obs_q[NBUF-1].addr); end
            total++; if (obs_q[0].data != 'h80) begin bad++; $display("FAIL cap_first_sample got=%0h want=80", obs_q[0].data); end
        end
        total++; if (dut.state_q !== WAIT) begin bad++; $display("FAIL cap_end_state got=%0d want=%0d", dut.state_q, WAIT); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wait_swap();
        for (int k = 0; k < 100; k++) drive(1'($urandom), SW'($urandom), 1'b0);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wait_writes got=%0d want=0", obs_q.size()); end
        total++; if (bus.read_index !== 1'b0) begin bad++; $display("FAIL wait_rd_held got=%0h want=0", bus.read_index); end
        drive(1'b0, '0, 1'b1);
        total++; if (bus.read_index !== 1'b1) begin bad++; $display("FAIL wait_rd_swap got=%0h want=1", bus.read_index); end
        total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL wait_exit_state got=%0d want=%0d", dut.state_q, ARMED); end
        capture_burst(NBUF, 2);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL cap2_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (obs_q[k] != exp_q[k]) begin
                bad++;
                $display("FAIL cap2_write[%0d] got=%0h@%0d want=%0h@%0d", k, obs_q[k].addr, obs_q[k].cyc, exp_q[k].addr, exp_q[k].cyc);
            end
        end
        if (obs_q.size() == NBUF) begin
            total++; if (obs_q[0].addr != 'h000) begin bad++; $display("FAIL cap2_first_addr got=%0h want=0", obs_q[0].addr); end
            total++; if (obs_q[NBUF-1].addr != 'h0FF) begin bad++; $display("FAIL cap2_last_addr got=%0h want=ff", obs_q[NBUF-1].addr); end
        end
        drive(1'b0, '0, 1'b1);
        total++; if (bus.read_index !== 1'b0) begin bad++; $display("FAIL cap2_rd_swap got=%0h want=0", bus.read_index); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_constant();
        do_reset(2);
        for (int k = 0; k < 2000; k++) drive(1'b1, SW'(1000), 1'b1);
        for (int k = 0; k < 200; k++) drive(1'b1, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL const_writes got=%0d want=0", obs_q.size()); end
        total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL const_state got=%0d want=%0d", dut.state_q, ARMED); end
        total++; if (bus.read_index !== 1'b0) begin bad++; $display("FAIL const_rd got=%0h want=0", bus.read_index); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        capture_burst(NBUF, 1);
        drive(1'b0, '0, 1'b1);
        total++; if (bus.read_index !== 1'b1) begin bad++; $display("FAIL mid_rd_pre got=%0h want=1", bus.read_index); end
        obs_q.delete(); exp_q.delete();
        capture_burst(50, 1);
        total++; if (obs_q.size() != 50) begin bad++; $display("FAIL mid_partial got=%0d want=50", obs_q.size()); end
        total++; if (obs_q.size() > 0 && obs_q[0].addr != 'h000) begin bad++; $display("FAIL mid_partial_addr got=%0h want=0", obs_q[0].addr); end
        reset = 1'b1;
        bus.new_sample_ready = 1'b1;
        bus.new_sample_in    = SW'($urandom);
        @(posedge clk);
        #1;
        total++; if (bus.write_enable !== 1'b0) begin bad++; $display("FAIL mid_we got=%0h want=0", bus.write_enable); end
        total++; if (bus.read_index !== 1'b0) begin bad++; $display("FAIL mid_rd got=%0h want=0", bus.read_index); end
        total++; if (dut.count_q !== '0) begin bad++; $display("FAIL mid_count got=%0d want=0", dut.count_q); end
        reset = 1'b0;
        model_reset();
        capture_burst(10, 1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL restart_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (obs_q[k] != exp_q[k]) begin
                bad++;
                $display("FAIL restart_write[%0d] got=%0h@%0d want=%0h@%0d", k, obs_q[k].addr, obs_q[k].cyc, exp_q[k].addr, exp_q[k].cyc);
            end
        end
        total++; if (obs_q.size() > 0 && obs_q[0].addr != 'h100) begin bad++; $display("FAIL restart_addr got=%0h want=100", obs_q[0].addr); end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        for (int k = 0; k < 300; k++) drive(1'b1, (k % 2 == 1) ? rand_pos() : rand_neg(), 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (obs_q[k] != exp_q[k]) begin
                bad++;
                $display("FAIL b2b_write[%0d] got=%0h/%0h@%0d want=%0h/%0h@%0d", k, obs_q[k].addr, obs_q[k].data,
                         obs_q[k].cyc, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
        for (int k = 1; k < obs_q.size(); k++) begin
            total++;
            if (obs_q[k].addr != obs_q[k-1].addr + 1 || obs_q[k].cyc != obs_q[k-1].cyc + 1) begin
                bad++;
                $display("FAIL b2b_contig[%0d] got=%0h@%0d want=%0h@%0d", k, obs_q[k].addr, obs_q[k].cyc,
                         obs_q[k-1].addr + 1, obs_q[k-1].cyc + 1);
            end
        end
    endtask

`ifdef WAVE_CAPTURE_DECIMATE_EN
    task automatic test_decimate();
        int trig_cyc;
        int t510;
        do_reset(2);
        t510 = -1;
        feed(rand_neg(), 1, 1'b0);
        trig_cyc = cyc;
        drive(1'b1, SW'(1000), 1'b0);
        for (int k = 1; k <= 600; k++) begin
            if (k == 510) t510 = cyc;
            drive(1'b1, SW'(1000 + k), 1'b0);
        end
        drive(1'b0, '0, 1'b0);
        total++; if (obs_q.size() != NBUF) begin bad++; $display("FAIL dec_count got=%0d want=%0d", obs_q.size(), NBUF); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL dec_model_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            total++;
            if (obs_q[k].cyc != trig_cyc + 2 * k + 1 || obs_q[k].addr != 'h100 + k) begin
                bad++;
                $display("FAIL dec_write[%0d] got=%0h@%0d want=%0h@%0d", k, obs_q[k].addr, obs_q[k].cyc, 'h100 + k, trig_cyc + 2 * k + 1);
            end
        end
        total++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1].cyc != t510 + 1) begin
            bad++;
            $display("FAIL dec_last_src got=%0d want=%0d", (obs_q.size() == 0) ? -1 : obs_q[obs_q.size()-1].cyc, t510 + 1);
        end
    endtask
`endif

    initial begin
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        model_reset();
        test_reset();
        test_capture();
        test_wait_swap();
        test_constant();
        test_reset_mid();
        test_back_to_back();
`ifdef WAVE_CAPTURE_DECIMATE_EN
        test_decimate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
# wave_capture

Downstream consumer of the music player's sample stream. On each `new_sample_generated` strobe it examines the 18-bit signed sample and, after a negative-to-non-negative zero crossing, writes 256 consecutive samples into one half of a double-buffered display RAM. When the display engine reports idle, it swaps buffers. The block sits between `music_player` (`sample_out`, `new_sample_generated`) and the wave display RAM write port.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 18, width of the incoming signed sample; must be ≥ 8.
- `DEPTH_LOG2`, 8, log2 of samples per capture; one buffer holds 2^DEPTH_LOG2 entries.
- `DECIM_LOG2`, 1, log2 of the decimation ratio; used only when `WAVE_CAPTURE_DECIMATE_EN` is defined.

Ports:
- `clk` in 1: system clock, the single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `new_sample_ready` in 1: one-cycle strobe; `new_sample_in` is valid this cycle.
- `new_sample_in` in `SAMPLE_WIDTH`: two's-complement sample.
- `wave_display_idle` in 1: level; high while the display is not reading RAM.
- `write_address` out `DEPTH_LOG2+1`: `{~read_index, index}` into the buffer not being displayed.
- `write_enable` out 1: one-cycle RAM write strobe.
- `write_sample` out 8: `{~s[W-1], s[W-2:W-8]}`, i.e. the top 8 bits converted to offset binary.
- `read_index` out 1: selects the buffer the display reads.

## Operation
- States:
  - `ARMED`: waits for a trigger.
  - `ACTIVE`: captures samples.
  - `WAIT`: holds a full buffer until the display is idle.
- `prev_msb` register:
  - Loads `new_sample_in[W-1]` on every `new_sample_ready`, in all states.
  - Reset value 0.
- Trigger: `new_sample_ready && prev_msb == 1 && new_sample_in[W-1] == 0`.
- `ARMED`:
  - On trigger, write the triggering sample at index 0, set `count = 1`, go to `ACTIVE`.
  - Non-trigger samples are not written.
- `ACTIVE`: each accepted sample is written at index `count`, then `count` increments.
  - A write at index 2^DEPTH_LOG2−1 moves the block to `WAIT`.
  - `count` wraps to 0.
- `WAIT`:
  - Samples are ignored apart from the `prev_msb` update.
  - The first cycle with `wave_display_idle == 1` toggles `read_index` and moves the block to `ARMED`.
- Writes always target buffer `~read_index`. The displayed buffer is never written.
- A constant-sign input never triggers. The block stays in `ARMED` indefinitely, with no writes.
- All samples equal to 0 never trigger, because `prev_msb` stays 0.
- Reset mid-capture:
  - Returns to `ARMED` and clears `count`, `prev_msb` and `read_index`.
  - The partial buffer is abandoned, not erased.

## Timing
- All outputs are registered.
- Reset values: `write_enable` 0, `write_address` 0, `write_sample` 0, `read_index` 0. State `ARMED`, `count` 0.
- Write latency: `write_enable` goes high exactly 1 cycle after the accepted `new_sample_ready`. `write_address` and `write_sample` are valid in that same cycle.
- Outside write cycles, `write_address` and `write_sample` hold their last value.
- The final write and the `WAIT` entry happen on the same clock edge.
- `wave_display_idle` is evaluated from the first `WAIT` cycle onward. The earliest buffer swap is 1 cycle after the final write strobe.
- A `new_sample_ready` arriving on the cycle `WAIT` exits to `ARMED`:
  - It updates `prev_msb`.
  - It is not evaluated as a trigger.
- Back-to-back strobes on consecutive cycles are supported, with one write per strobe.

## Configuration
- Macro: `WAVE_CAPTURE_DECIMATE_EN`.
- Defined:
  - In `ACTIVE`, a `DECIM_LOG2`-bit phase counter advances on each `new_sample_ready`.
  - Only samples with phase == 0 are written, so every 2^DECIM_LOG2-th sample after the trigger is kept.
  - The phase counter clears on trigger and on reset. The trigger sample is always written at index 0.
- Undefined: every sample in `ACTIVE` is written, no phase counter is instantiated, and `DECIM_LOG2` is ignored.

## Structure
- Shared package `wave_pkg`:
  - State encoding constants `ARMED`, `ACTIVE`, `WAIT`.
  - Default `SAMPLE_WIDTH` and `DEPTH_LOG2`.
  - The offset-binary conversion function.
- Sub-module `zero_cross_detect`:
  - Holds `prev_msb`.
  - Outputs a combinational `trigger` qualified by `new_sample_ready`.
- The FSM, counters and output registers live in `wave_capture`.

## Test plan
- Reset, then samples −5, +3, then 255 more positive samples spaced 4 cycles apart:
  - 256 writes at addresses 0x100–0x1FF.
  - First `write_sample` is `{1'b1, top bits of +3}`.
  - FSM ends in `WAIT`.
- Full buffer with `wave_display_idle = 0` for 100 cycles, then 1:
  - No writes during the wait.
  - `read_index` flips to 1 one cycle after idle rises.
  - The next capture uses addresses 0x000–0x0FF.
- Constant +1000 for 2000 strobes: zero writes, state stays `ARMED`.
- `reset` asserted after 50 captured samples:
  - Next cycle `write_enable = 0`, `read_index = 0`.
  - A new trigger restarts at index 0.
- With `WAVE_CAPTURE_DECIMATE_EN` and `DECIM_LOG2 = 1`, a trigger followed by a ramp of 600 samples:
  - Writes come only on even-offset samples after the trigger.
  - 256 writes occur, and the last source sample is trigger + 510.
- Strobes on consecutive cycles with alternating sign: each write appears exactly 1 cycle after its strobe, and addresses are contiguous.
